pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 11 +
 rtl/ripple_adder_chunk.sv | 29 ++
 rtl/pipelined_adder.sv | 155 +++++++++++++++
 tb/tb_pipelined_adder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the pipelined add/subtract unit
package adder_pkg;

    localparam logic ADD    = 1'b0;
    localparam logic SUB_OP = 1'b1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ripple_adder_chunk.sv
// rtl/ripple_adder_chunk.sv - combinational W-bit ripple slice built from full-adder cells
module ripple_adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         CI,
    output logic [W-1:0] S,
    output logic         CO,
    output logic         C_MSB_IN
);

    logic [W:0] carry;

    // carry[i] is the carry into cell i; the chain is kept inside one process
    always_comb begin
        carry    = '0;
        S        = '0;
        carry[0] = CI;
        for (int i = 0; i < W; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    end

    assign CO       = carry[W];
    assign C_MSB_IN = carry[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/subtract pipelined in CHUNK-bit ripple slices with valid/ready
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             C_in,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             C_out,
    output logic             OVF
);

    localparam int STAGES = ceil_div(WIDTH, CHUNK);

    logic advance;

    // Element k is the input of stage k: element 0 comes from the ports, the rest from stage registers
    logic [STAGES-1:0][WIDTH-1:0] a_lnk;
    logic [STAGES-1:0][WIDTH-1:0] b_lnk;
    logic [STAGES-1:0][WIDTH-1:0] s_lnk;
    logic [STAGES-1:0]            c_lnk;
    logic [STAGES-1:0]            v_lnk;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    assign a_lnk[0] = X;
    assign b_lnk[0] = Y ^ {WIDTH{SUB}};
    assign c_lnk[0] = (SUB == SUB_OP) ? 1'b1 : C_in;
    assign s_lnk[0] = '0;
    assign v_lnk[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int SW = (k == STAGES - 1) ? (WIDTH - LO) : CHUNK;

        logic [SW-1:0]    slice;
        logic             co;
        logic             cmsb;
        logic [WIDTH-1:0] slice_ext;

        ripple_adder_chunk #(.W(SW)) u_chunk (
            .A        (a_lnk[k][LO +: SW]),
            .B        (b_lnk[k][LO +: SW]),
            .CI       (c_lnk[k]),
            .S        (slice),
            .CO       (co),
            .C_MSB_IN (cmsb)
        );

        assign slice_ext = WIDTH'(slice) << LO;

        if (k > 0) begin : g_consumed
            logic unused_consumed;
            assign unused_consumed = ^{a_lnk[k][LO-1:0], b_lnk[k][LO-1:0]};
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q, a_d;
            logic [WIDTH-1:0] b_q, b_d;
            logic [WIDTH-1:0] s_q, s_d;
            logic             c_q, c_d;
            logic             v_q, v_d;
            logic             unused_cmsb;

            assign unused_cmsb = cmsb;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                s_d = s_q;
                c_d = c_q;
                v_d = v_q;
                if (advance) begin
                    a_d = a_lnk[k];
                    b_d = b_lnk[k];
                    s_d = s_lnk[k] | slice_ext;
                    c_d = co;
                    v_d = v_lnk[k];
                end
            end

            always_ff @(posedge CLK or negedge RST_n) begin
                if (!RST_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    s_q <= s_d;
                    c_q <= c_d;
                    v_q <= v_d;
                end
            end

            assign a_lnk[k+1] = a_q;
            assign b_lnk[k+1] = b_q;
            assign s_lnk[k+1] = s_q;
            assign c_lnk[k+1] = c_q;
            assign v_lnk[k+1] = v_q;
        end else begin : g_last
            logic [WIDTH-1:0] z_q, z_d;
            logic             co_q, co_d;
            logic             ovf_q, ovf_d;
            logic             v_q, v_d;

            // Signed overflow: carry into the MSB disagrees with carry out of it
            always_comb begin
                z_d   = z_q;
                co_d  = co_q;
                ovf_d = ovf_q;
                v_d   = v_q;
                if (advance) begin
                    z_d   = s_lnk[k] | slice_ext;
                    co_d  = co;
                    ovf_d = cmsb ^ co;
                    v_d   = v_lnk[k];
                end
            end

            always_ff @(posedge CLK or negedge RST_n) begin
                if (!RST_n) begin
                    z_q   <= '0;
                    co_q  <= 1'b0;
                    ovf_q <= 1'b0;
                    v_q   <= 1'b0;
                end else begin
                    z_q   <= z_d;
                    co_q  <= co_d;
                    ovf_q <= ovf_d;
                    v_q   <= v_d;
                end
            end

            assign Z         = z_q;
            assign C_out     = co_q;
            assign OVF       = ovf_q;
            assign out_valid = v_q;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder (8/4 and 10/4 configurations)
module tb_pipelined_adder;

    typedef struct {
        logic [15:0] z;
        logic        c;
        logic        o;
        int          acc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_in_valid, a_in_ready, a_c_in, a_sub, a_out_valid, a_out_ready, a_c_out, a_ovf;
    logic [7:0] a_x, a_y, a_z;
    logic       b_in_valid, b_in_ready, b_c_in, b_sub, b_out_valid, b_out_ready, b_c_out, b_ovf;
    logic [9:0] b_x, b_y, b_z;

    pipelined_adder #(.WIDTH(8), .CHUNK(4)) u_dut_a (
        .CLK(clk), .RST_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .X(a_x), .Y(a_y), .C_in(a_c_in), .SUB(a_sub), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .Z(a_z), .C_out(a_c_out), .OVF(a_ovf)
    );

    pipelined_adder #(.WIDTH(10), .CHUNK(4)) u_dut_b (
        .CLK(clk), .RST_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .X(b_x), .Y(b_y), .C_in(b_c_in), .SUB(b_sub), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .Z(b_z), .C_out(b_c_out), .OVF(b_ovf)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         stall_cnt = 0;
    int         a_popped = 0;
    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       pend_a, pend_b;
    logic [7:0] held_z;
    bit         stalled_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sub);
        exp_t e;
        int   ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sub) begin
            r   = ux - uy;
            sr  = sx - sy;
            e.c = (ux >= uy);
        end else begin
            r   = ux + uy + int'(ci);
            sr  = sx + sy + int'(ci);
            e.c = (r > 255);
        end
        e.z       = 16'(r & 255);
        e.o       = (sr > 127) || (sr < -128);
        e.acc     = 0;
        e.chk_lat = 0;
        return e;
    endfunction

    task automatic cycle(output bit acc_a, output bit acc_b);
        exp_t e;
        @(negedge clk);
        acc_a = 0;
        acc_b = 0;
        if (a_out_valid && a_out_ready) begin
            chk("a_extra_output", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                a_popped++;
                chk("a_z", a_z, e.z);
                chk("a_c_out", a_c_out, e.c);
                chk("a_ovf", a_ovf, e.o);
                if (e.chk_lat) chk("a_latency", cyc - e.acc, 2);
            end
        end
        if (a_out_valid && !a_out_ready) begin
            stall_cnt++;
            chk("a_stall_in_ready", a_in_ready, 0);
            if (qa.size() > 0) chk("a_stall_z_head", a_z, qa[0].z);
            if (stalled_prev) chk("a_stall_z_hold", a_z, held_z);
            held_z = a_z;
            stalled_prev = 1;
        end else begin
            stalled_prev = 0;
        end
        if (a_in_valid && a_in_ready) begin
            e = pend_a;
            e.acc = cyc;
            qa.push_back(e);
            acc_a = 1;
        end
        if (b_out_valid && b_out_ready) begin
            chk("b_extra_output", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_z", b_z, e.z);
                chk("b_c_out", b_c_out, e.c);
                chk("b_ovf", b_ovf, e.o);
                if (e.chk_lat) chk("b_latency", cyc - e.acc, 3);
            end
        end
        if (b_in_valid && b_in_ready) begin
            e = pend_b;
            e.acc = cyc;
            qb.push_back(e);
            acc_b = 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sub,
                          input logic [7:0] ez, input logic ec, input logic eo);
        bit ok, okb;
        a_x = x; a_y = y; a_c_in = ci; a_sub = sub; a_in_valid = 1'b1;
        pend_a = '{z: 16'(ez), c: ec, o: eo, acc: 0, chk_lat: 1'b1};
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) cycle(ok, okb);
        chk("a_accept", 32'(ok), 1);
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [9:0] x, input logic [9:0] y, input logic ci, input logic sub,
                          input logic [9:0] ez, input logic ec, input logic eo);
        bit oka, ok;
        b_x = x; b_y = y; b_c_in = ci; b_sub = sub; b_in_valid = 1'b1;
        pend_b = '{z: 16'(ez), c: ec, o: eo, acc: 0, chk_lat: 1'b1};
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) cycle(oka, ok);
        chk("b_accept", 32'(ok), 1);
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit d0, d1;
        for (int t = 0; t < 20 && (qa.size() > 0 || qb.size() > 0); t++) cycle(d0, d1);
        chk(tag, 32'(qa.size() + qb.size()), 0);
    endtask

    initial begin
        bit acc, accb, have;
        int n;

        rst_n = 1'b0;
        a_in_valid = 0; a_x = '0; a_y = '0; a_c_in = 0; a_sub = 0; a_out_ready = 1'b0;
        b_in_valid = 0; b_x = '0; b_y = '0; b_c_in = 0; b_sub = 0; b_out_ready = 1'b1;
        pend_a = '{z: 16'h0, c: 1'b0, o: 1'b0, acc: 0, chk_lat: 1'b0};
        pend_b = pend_a;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_z", a_z, 0);
        chk("reset_c_out", a_c_out, 0);
        chk("reset_ovf", a_ovf, 0);
        chk("reset_in_ready", a_in_ready, 1);
        chk("reset_b_out_valid", b_out_valid, 0);
        rst_n = 1'b1;
        a_out_ready = 1'b1;

        send_a(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);
        drain("t1_drain");
        send_a(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        drain("t2a_drain");
        send_a(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        drain("t2b_drain");
        send_a(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        drain("t3a_drain");
        send_a(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        drain("t3b_drain");

        // Back-to-back stream with a 3-cycle consumer stall in the middle
        stall_cnt = 0;
        a_popped = 0;
        n = 1;
        for (int t = 0; t < 40 && (n <= 6 || qa.size() > 0); t++) begin
            a_out_ready = !(t >= 3 && t < 6);
            a_in_valid = (n <= 6);
            a_x = 8'(n); a_y = 8'(2 * n); a_c_in = 1'b0; a_sub = 1'b0;
            pend_a = '{z: 16'(3 * n), c: 1'b0, o: 1'b0, acc: 0, chk_lat: 1'b0};
            cycle(acc, accb);
            if (acc) n++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        chk("t4_accepted", n, 7);
        chk("t4_delivered", a_popped, 6);
        chk("t4_stall_cycles", stall_cnt, 3);
        chk("t4_queue_empty", 32'(qa.size()), 0);

        // Random add/sub traffic with random backpressure
        n = 0;
        have = 0;
        for (int t = 0; t < 300 && (n < 20 || qa.size() > 0); t++) begin
            a_out_ready = ($urandom_range(0, 3) != 0);
            if (!have && n < 20 && $urandom_range(0, 1) == 1) begin
                a_x = 8'($urandom); a_y = 8'($urandom);
                a_c_in = 1'($urandom); a_sub = 1'($urandom);
                pend_a = model8(a_x, a_y, a_c_in, a_sub);
                have = 1;
            end
            a_in_valid = have;
            cycle(acc, accb);
            if (acc) begin
                have = 0;
                n++;
            end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        chk("rand_accepted", n, 20);
        chk("rand_drained", 32'(qa.size()), 0);

        // Reset with two beats in flight
        a_x = 8'h11; a_y = 8'h22; a_c_in = 0; a_sub = 0; a_in_valid = 1'b1;
        pend_a = '{z: 16'h33, c: 1'b0, o: 1'b0, acc: 0, chk_lat: 1'b0};
        cycle(acc, accb);
        a_x = 8'h01; a_y = 8'h01;
        pend_a = '{z: 16'h02, c: 1'b0, o: 1'b0, acc: 0, chk_lat: 1'b0};
        cycle(acc, accb);
        a_in_valid = 1'b0;
        chk("t5_pre_reset_valid", a_out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_out_valid", a_out_valid, 0);
        chk("t5_reset_z", a_z, 0);
        chk("t5_reset_c_out", a_c_out, 0);
        chk("t5_reset_ovf", a_ovf, 0);
        qa.delete();
        stalled_prev = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_held_in_reset", a_out_valid, 0);
        rst_n = 1'b1;
        send_a(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        drain("t5_drain");
        repeat (3) cycle(acc, accb);

        // WIDTH=10, CHUNK=4: three stages with a 2-bit top slice
        send_b(10'h3FF, 10'h001, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
        drain("t6a_drain");
        send_b(10'h1FF, 10'h001, 1'b0, 1'b0, 10'h200, 1'b0, 1'b1);
        drain("t6b_drain");
        send_b(10'h200, 10'h001, 1'b0, 1'b1, 10'h1FF, 1'b1, 1'b1);
        drain("t6c_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
